// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state type and default bus widths.
package mem_port_arbiter_pkg;

    localparam int unsigned DefAddrW   = 32;
    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefTimeout = 255;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StFetch
    } arb_state_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Bus watchdog: counts cycles without acknowledge and flags when the limit is reached.
module arb_timeout_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned Limit = DefTimeout,
    localparam int unsigned CntW = (Limit < 1) ? 1 : $clog2(Limit + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign expired_o = (cnt_q == CntW'(Limit));

    // Clear has priority; saturate at the limit so the flag stays stable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch and data access,
// one bus transaction at a time, and holds results until the pipeline advances.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic                clk,
    input  logic                reset_n,
    // Fetch side
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                if_err,
    // Data side
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_sel,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                dm_err,
    // Bus master
    output logic                bus_cyc,
    output logic                bus_stb,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_adr,
    output logic [DATA_W-1:0]   bus_dat_o,
    output logic [DATA_W/8-1:0] bus_sel,
    input  logic [DATA_W-1:0]   bus_dat_i,
    input  logic                bus_ack,
    // Pipeline control
    output logic                stall_pipl
);

    localparam int unsigned SelW = DATA_W / 8;

    arb_state_t        state_q;
    logic              bus_cyc_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_adr_q;
    logic [DATA_W-1:0] bus_dat_q;
    logic [SelW-1:0]   bus_sel_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_done_q;
    logic              if_err_q;
    logic              dm_done_q;
    logic              dm_err_q;

    logic pend_dm;
    logic pend_if;
    logic busy;
    logic expired;

    assign pend_dm    = dm_req & ~dm_done_q;
    assign pend_if    = if_req & ~if_done_q;
    assign busy       = (state_q != StIdle);
    assign stall_pipl = pend_dm | pend_if | busy;

    // Counter is held clear while idle, so it starts from zero on every grant.
    arb_timeout_counter #(
        .Limit (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .clr_i     (~busy),
        .en_i      (busy & ~bus_ack),
        .expired_o (expired)
    );

    // Arbiter FSM with registered bus outputs and held results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            bus_cyc_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_adr_q  <= '0;
            bus_dat_q  <= '0;
            bus_sel_q  <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            if_err_q   <= 1'b0;
            dm_done_q  <= 1'b0;
            dm_err_q   <= 1'b0;
        end else begin
            // The pipeline advances on this edge, so held results are consumed.
            if (!stall_pipl) begin
                if_done_q <= 1'b0;
                if_err_q  <= 1'b0;
                dm_done_q <= 1'b0;
                dm_err_q  <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    // Data first: it belongs to the older instruction.
                    if (pend_dm) begin
                        state_q   <= StData;
                        bus_cyc_q <= 1'b1;
                        bus_we_q  <= dm_we;
                        bus_adr_q <= dm_addr;
                        bus_dat_q <= dm_wdata;
                        bus_sel_q <= dm_sel;
                    end else if (pend_if) begin
                        state_q   <= StFetch;
                        bus_cyc_q <= 1'b1;
                        bus_we_q  <= 1'b0;
                        bus_adr_q <= if_addr;
                        bus_dat_q <= '0;
                        bus_sel_q <= '1;
                    end
                end
                StData: begin
                    if (bus_ack) begin
                        state_q    <= StIdle;
                        bus_cyc_q  <= 1'b0;
                        dm_rdata_q <= bus_dat_i;
                        dm_done_q  <= 1'b1;
                        dm_err_q   <= 1'b0;
                    end else if (expired) begin
                        state_q   <= StIdle;
                        bus_cyc_q <= 1'b0;
                        dm_done_q <= 1'b1;
                        dm_err_q  <= 1'b1;
                    end
                end
                StFetch: begin
                    if (bus_ack) begin
                        state_q    <= StIdle;
                        bus_cyc_q  <= 1'b0;
                        if_rdata_q <= bus_dat_i;
                        if_done_q  <= 1'b1;
                        if_err_q   <= 1'b0;
                    end else if (expired) begin
                        state_q   <= StIdle;
                        bus_cyc_q <= 1'b0;
                        if_done_q <= 1'b1;
                        if_err_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    bus_cyc_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_cyc   = bus_cyc_q;
    assign bus_stb   = bus_cyc_q;
    assign bus_we    = bus_we_q;
    assign bus_adr   = bus_adr_q;
    assign bus_dat_o = bus_dat_q;
    assign bus_sel   = bus_sel_q;

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_done   = dm_done_q;
    assign dm_err    = dm_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of transactions plus hand sequences,
// with a bus-request scoreboard consumed by a cycle-level bus responder.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned TO = 7;

    logic          clk;
    logic          reset_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          if_err;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [SW-1:0] dm_sel;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          dm_err;
    logic          bus_cyc;
    logic          bus_stb;
    logic          bus_we;
    logic [AW-1:0] bus_adr;
    logic [DW-1:0] bus_dat_o;
    logic [SW-1:0] bus_sel;
    logic [DW-1:0] bus_dat_i;
    logic          bus_ack;
    logic          stall_pipl;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .if_err     (if_err),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_sel     (dm_sel),
        .dm_rdata   (dm_rdata),
        .dm_done    (dm_done),
        .dm_err     (dm_err),
        .bus_cyc    (bus_cyc),
        .bus_stb    (bus_stb),
        .bus_we     (bus_we),
        .bus_adr    (bus_adr),
        .bus_dat_o  (bus_dat_o),
        .bus_sel    (bus_sel),
        .bus_dat_i  (bus_dat_i),
        .bus_ack    (bus_ack),
        .stall_pipl (stall_pipl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          dm_req;
        logic          dm_we;
        logic [AW-1:0] dm_addr;
        logic [DW-1:0] dm_wdata;
        logic [SW-1:0] dm_sel;
        int            dm_lat;      // stb cycle index of ack, -1 = never
        logic [DW-1:0] dm_bus_data;
        logic          dm_drop;     // drop dm_req in the second bus cycle
        logic          if_req;
        logic [AW-1:0] if_addr;
        int            if_lat;
        logic [DW-1:0] if_bus_data;
        logic          exp_dm_err;
        logic          exp_if_err;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int            lat;
        logic [DW-1:0] rdata;
        logic          is_dm;
        logic          drop;
    } bus_exp_t;

    bus_exp_t      sb_q[$];
    bus_exp_t      cur;
    logic          have_cur;
    logic          prev_cyc;
    int            idx;
    int            checks;
    int            errors;
    logic [DW-1:0] m_dm_rdata;
    logic [DW-1:0] m_if_rdata;
    vec_t          vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int eff(input int lat);
        return (lat < 0) ? int'(TO) : lat;
    endfunction

    function automatic vec_t mk(input logic dreq, input logic dwe, input logic [AW-1:0] dadr,
                                input logic [DW-1:0] dwd, input logic [SW-1:0] dsel,
                                input int dlat, input logic [DW-1:0] ddat, input logic ddrop,
                                input logic ireq, input logic [AW-1:0] iadr, input int ilat,
                                input logic [DW-1:0] idat);
        vec_t v;
        v.dm_req = dreq;   v.dm_we = dwe;       v.dm_addr = dadr;     v.dm_wdata = dwd;
        v.dm_sel = dsel;   v.dm_lat = dlat;     v.dm_bus_data = ddat; v.dm_drop = ddrop;
        v.if_req = ireq;   v.if_addr = iadr;    v.if_lat = ilat;      v.if_bus_data = idat;
        v.exp_dm_err = dreq && (dlat < 0);
        v.exp_if_err = ireq && (ilat < 0);
        return v;
    endfunction

    // Bus responder and scoreboard consumer; called once per cycle just after negedge.
    task automatic respond();
        if (bus_cyc) begin
            if (!prev_cyc) begin
                idx = 0;
                if (sb_q.size() == 0) begin
                    have_cur = 1'b0;
                    check("bus_unexpected", 1, 0);
                end else begin
                    cur = sb_q.pop_front();
                    have_cur = 1'b1;
                    check("bus_we", bus_we, cur.we);
                    check("bus_adr", bus_adr, cur.adr);
                    check("bus_sel", bus_sel, cur.sel);
                    check("bus_stb", bus_stb, 1);
                    if (cur.we) check("bus_dat_o", bus_dat_o, cur.dat);
                end
            end else begin
                idx++;
            end
            if (have_cur && cur.is_dm && cur.drop && idx == 1) dm_req = 1'b0;
            if (have_cur && cur.lat >= 0 && idx == cur.lat) begin
                bus_ack   = 1'b1;
                bus_dat_i = cur.rdata;
                if (cur.is_dm) m_dm_rdata = cur.rdata;
                else           m_if_rdata = cur.rdata;
            end else begin
                bus_ack   = 1'b0;
                bus_dat_i = $urandom;
            end
        end else begin
            if (prev_cyc && have_cur) check("stb_cycles", idx + 1, eff(cur.lat) + 1);
            bus_ack   = 1'b0;
            bus_dat_i = $urandom;
        end
        prev_cyc = bus_cyc;
    endtask

    // Apply one record at a negedge, run until the pipeline is released, then check results.
    task automatic run_vec(input vec_t v, input string tag);
        bus_exp_t e;
        int exp_stall;
        int stall_cnt;
        int budget;
        exp_stall = 0;
        dm_req   = v.dm_req;
        dm_we    = v.dm_we;
        dm_addr  = v.dm_addr;
        dm_wdata = v.dm_wdata;
        dm_sel   = v.dm_sel;
        if_req   = v.if_req;
        if_addr  = v.if_addr;
        if (v.dm_req) begin
            e = '{we: v.dm_we, adr: v.dm_addr, dat: v.dm_wdata, sel: v.dm_sel, lat: v.dm_lat,
                  rdata: v.dm_bus_data, is_dm: 1'b1, drop: v.dm_drop};
            sb_q.push_back(e);
            exp_stall += 2 + eff(v.dm_lat);
        end
        if (v.if_req) begin
            e = '{we: 1'b0, adr: v.if_addr, dat: '0, sel: '1, lat: v.if_lat,
                  rdata: v.if_bus_data, is_dm: 1'b0, drop: 1'b0};
            sb_q.push_back(e);
            exp_stall += 2 + eff(v.if_lat);
        end
        #1;
        stall_cnt = 0;
        budget = 200;
        while (stall_pipl && budget > 0) begin
            stall_cnt++;
            @(posedge clk);
            @(negedge clk);
            respond();
            #1;
            budget--;
        end
        if (budget == 0) check({tag, "_wait_budget"}, 1, 0);
        check({tag, "_stall_cycles"}, stall_cnt, exp_stall);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
        check({tag, "_dm_done"}, dm_done, v.dm_req);
        check({tag, "_dm_err"}, dm_err, v.exp_dm_err);
        check({tag, "_dm_rdata"}, dm_rdata, m_dm_rdata);
        check({tag, "_if_done"}, if_done, v.if_req);
        check({tag, "_if_err"}, if_err, v.exp_if_err);
        check({tag, "_if_rdata"}, if_rdata, m_if_rdata);
        // Pipeline advances: results must be consumed on this edge.
        dm_req = 1'b0;
        if_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        respond();
        #1;
        check({tag, "_dm_done_clr"}, {dm_done, dm_err}, 2'b00);
        check({tag, "_if_done_clr"}, {if_done, if_err}, 2'b00);
        check({tag, "_idle_cyc"}, bus_cyc, 0);
        check({tag, "_idle_stall"}, stall_pipl, 0);
    endtask

    initial begin
        bus_exp_t e;
        vec_t     rv;
        checks = 0;
        errors = 0;
        have_cur = 1'b0;
        prev_cyc = 1'b0;
        idx = 0;
        m_dm_rdata = '0;
        m_if_rdata = '0;
        reset_n = 1'b0;
        if_req = 1'b0;  if_addr = '0;
        dm_req = 1'b0;  dm_we = 1'b0;  dm_addr = '0;  dm_wdata = '0;  dm_sel = '0;
        bus_ack = 1'b0; bus_dat_i = '0;

        //                 dreq  dwe   dm_addr       dm_wdata      sel   dlat dm_bus_data   drop
        //                 ireq  if_addr       ilat  if_bus_data
        vecs[0] = mk(1'b0, 1'b0, 32'h0,          32'h0,          4'h0, 0,  32'h0,          1'b0,
                     1'b1, 32'h0000_0100, 2,  32'h0000_0013);
        vecs[1] = mk(1'b1, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'h3, 0,  32'h0000_00A5, 1'b0,
                     1'b1, 32'h0000_0104, 0,  32'h0050_0093);
        vecs[2] = mk(1'b1, 1'b0, 32'h0000_3000, 32'h0,          4'hF, -1, 32'h0,          1'b0,
                     1'b1, 32'h0000_0108, 1,  32'h0010_0113);
        vecs[3] = mk(1'b1, 1'b0, 32'h0000_3004, 32'h0,          4'hF, TO, 32'hCAFE_F00D, 1'b0,
                     1'b0, 32'h0,          0,  32'h0);
        vecs[4] = mk(1'b1, 1'b0, 32'h0000_0040, 32'h0,          4'hC, 3,  32'h1234_5678, 1'b1,
                     1'b0, 32'h0,          0,  32'h0);
        vecs[5] = mk(1'b0, 1'b0, 32'h0,          32'h0,          4'h0, 0,  32'h0,          1'b0,
                     1'b1, 32'h0000_010C, -1, 32'h0);
        vecs[6] = mk(1'b1, 1'b0, 32'h0000_0044, 32'h0,          4'h1, 0,  32'h0000_0077, 1'b0,
                     1'b0, 32'h0,          0,  32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus", {bus_cyc, bus_stb, bus_we, bus_adr, bus_sel}, '0);
        check("rst_bus_dat", bus_dat_o, 0);
        check("rst_flags", {dm_done, dm_err, if_done, if_err}, 4'b0000);
        check("rst_rdata", {dm_rdata, if_rdata}, 64'h0);
        check("rst_stall", stall_pipl, 0);
        reset_n = 1'b1;

        // bus_ack while idle must be ignored
        @(negedge clk);
        bus_ack = 1'b1;
        bus_dat_i = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("idle_ack_flags", {dm_done, if_done, dm_err, if_err}, 4'b0000);
        check("idle_ack_rdata", {dm_rdata, if_rdata}, 64'h0);
        check("idle_ack_cyc", bus_cyc, 0);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a fetch wait
        if_req = 1'b1;
        if_addr = 32'h0000_0200;
        e = '{we: 1'b0, adr: 32'h0000_0200, dat: '0, sel: '1, lat: -1, rdata: '0,
              is_dm: 1'b0, drop: 1'b0};
        sb_q.push_back(e);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            respond();
        end
        #2;
        check("arst_pre_cyc", bus_cyc, 1);
        reset_n = 1'b0;
        #1;
        check("arst_cyc", {bus_cyc, bus_stb}, 2'b00);
        check("arst_flags", {if_done, if_err, dm_done, dm_err}, 4'b0000);
        check("arst_stall", stall_pipl, 1);
        m_dm_rdata = '0;
        m_if_rdata = '0;
        prev_cyc = 1'b0;
        have_cur = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("arst_hold_cyc", bus_cyc, 0);
        reset_n = 1'b1;
        rv = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1'b0,
                1'b1, 32'h0000_0200, 1, 32'h0000_0033);
        run_vec(rv, "arst_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
